// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: default width,
// repetition field width and the controller state encoding.
package seq_pattern_pkg;

    // Default pattern register width in bits.
    localparam int unsigned SEQ_W_DEFAULT = 16;

    // Width of the extra-repetition field (pattern is sent rep+1 times).
    localparam int unsigned SEQ_REP_W = 4;

    // Transmitter controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_bit_counter.sv
// Bit-index and repetition counter for the serial pattern transmitter.
// idx_o is the index of the bit currently on the line; wrap_o flags that the
// next step restarts the pattern, end_o that the current bit is the last one.
module seq_bit_counter
    import seq_pattern_pkg::*;
#(
    parameter int unsigned LW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [LW-1:0]        len_i,
    input  logic [SEQ_REP_W-1:0] rep_i,
    input  logic                 dec_i,
    output logic [LW-1:0]        idx_o,
    output logic                 wrap_o,
    output logic                 end_o
);

    logic [LW-1:0]        idx_q;
    logic [LW-1:0]        last_idx_q;
    logic [SEQ_REP_W-1:0] rep_q;
    logic                 last_bit;

    assign last_bit = (idx_q == last_idx_q);
    assign wrap_o   = last_bit && (rep_q != '0);
    assign end_o    = last_bit && (rep_q == '0);
    assign idx_o    = idx_q;

    // Load the run parameters on acceptance, then advance one bit per step,
    // wrapping to bit 0 and consuming one repetition at the end of each pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            last_idx_q <= '0;
            rep_q      <= '0;
        end else if (load_i) begin
            idx_q      <= '0;
            last_idx_q <= len_i - LW'(1);
            rep_q      <= rep_i;
        end else if (dec_i) begin
            if (!last_bit) begin
                idx_q <= idx_q + LW'(1);
            end else if (rep_q != '0) begin
                idx_q <= '0;
                rep_q <= rep_q - SEQ_REP_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a W-bit pattern with a length and a
// repetition count, then streams it LSB first, one bit per clock, followed by
// a one-cycle done pulse. All outputs come straight from flops.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int unsigned W  = SEQ_W_DEFAULT,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_valid,
    input  logic [W-1:0]         ld_data,
    input  logic [LW-1:0]        ld_len,
    input  logic [SEQ_REP_W-1:0] ld_rep,
    output logic                 ld_ready,
    output logic                 o_d,
    output logic                 o_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LW-1:0] W_L = LW'(W);

    seq_state_e    state_q;
    logic [W-1:0]  pat_q;
    logic          o_d_q;
    logic          o_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          ld_ready_q;

    logic          accept;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] idx;
    logic          wrap;
    logic          last_pass_end;
    logic [W-1:0]  pat_sh;
    logic          next_bit;

    assign accept = ld_valid && ld_ready_q;

    // Out-of-range lengths (0 or above W) fall back to the full pattern width.
    always_comb begin
        len_eff = ld_len;
        if ((ld_len == '0) || (ld_len > W_L)) begin
            len_eff = W_L;
        end
    end

    // Bit that goes on the line at the next edge while shifting.
    always_comb begin
        pat_sh   = pat_q >> (idx + LW'(1));
        next_bit = wrap ? pat_q[0] : pat_sh[0];
    end

    seq_bit_counter #(
        .LW (LW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .len_i  (len_eff),
        .rep_i  (ld_rep),
        .dec_i  (state_q == ST_SHIFT),
        .idx_o  (idx),
        .wrap_o (wrap),
        .end_o  (last_pass_end)
    );

    // Controller FSM with registered outputs; bit 0 is launched on the
    // acceptance edge so it appears in the very next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            o_d_q      <= 1'b0;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        pat_q      <= ld_data;
                        o_d_q      <= ld_data[0];
                        o_valid_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        ld_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_pass_end) begin
                        o_d_q     <= 1'b0;
                        o_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        o_d_q <= next_bit;
                    end
                end
                ST_DONE: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    o_d_q      <= 1'b0;
                    o_valid_q  <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_ready = ld_ready_q;
    assign o_d      = o_d_q;
    assign o_valid  = o_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: each load pushes its expected bit
// stream plus a done token; a negedge monitor pops and compares.
module tb_seq_pattern_tx;

    localparam int W  = 16;
    localparam int LW = 5;
    localparam int DONE_TOK = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic [W-1:0]  ld_data;
    logic [LW-1:0] ld_len;
    logic [3:0]    ld_rep;
    logic          ld_ready;
    logic          o_d;
    logic          o_valid;
    logic          busy;
    logic          done;

    int q[$];
    bit active;
    int n_checks;
    int n_fail;

    seq_pattern_tx #(
        .W (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_len   (ld_len),
        .ld_rep   (ld_rep),
        .ld_ready (ld_ready),
        .o_d      (o_d),
        .o_valid  (o_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expected items whenever the DUT presents a bit or done.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_is_not_busy", ld_ready, !busy);
            if (!o_valid) chk("o_d_zero_when_invalid", o_d, 0);
            if (o_valid) begin
                chk("bit_expected", q.size() > 0, 1);
                if (q.size() > 0) chk("o_d_bit", o_d, q.pop_front());
                active = 1'b1;
            end else if (done) begin
                chk("done_expected", q.size() > 0, 1);
                if (q.size() > 0) chk("done_pulse", q.pop_front(), DONE_TOK);
                active = 1'b0;
            end else if (active) begin
                chk("stream_gap", {o_valid, done}, 1);
            end
        end
    end

    // Reference: effective length, then the pattern LSB first, rep+1 times.
    function automatic int eff_len(input int len);
        return (len == 0 || len > W) ? W : len;
    endfunction

    task automatic push_expect(input logic [W-1:0] d, input int len, input int rep);
        int le;
        le = eff_len(len);
        for (int r = 0; r <= rep; r++)
            for (int k = 0; k < le; k++)
                q.push_back(int'((d >> k) & 1));
        q.push_back(DONE_TOK);
    endtask

    // Issue one load at a negedge and track it until ld_ready returns.
    task automatic do_load(input logic [W-1:0] d, input int len, input int rep, input bit spurious);
        int n;
        int cyc;
        cyc = 0;
        while (!ld_ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_load", ld_ready, 1);
        n = eff_len(len) * (rep + 1);
        push_expect(d, len, rep);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_len   = LW'(len);
        ld_rep   = 4'(rep);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_data  = W'($urandom);
        ld_len   = LW'($urandom);
        ld_rep   = 4'($urandom);
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("first_bit_latency", o_valid, 1);
            if (ld_ready) break;
            if (spurious && cyc == 2 && n >= 2) begin
                ld_valid = 1'b1;
                ld_data  = ~d;
                ld_len   = LW'(1);
                ld_rep   = 4'd0;
            end else begin
                ld_valid = 1'b0;
            end
        end
        ld_valid = 1'b0;
        chk("ready_return_cycle", cyc, n + 2);
    endtask

    // Abort a 16-bit transfer between edges while bit 5 is on the line.
    task automatic reset_mid_transfer();
        int cyc;
        cyc = 0;
        while (!ld_ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        push_expect(16'hA5C3, 16, 0);
        ld_valid = 1'b1;
        ld_data  = 16'hA5C3;
        ld_len   = LW'(16);
        ld_rep   = 4'd0;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_transfer_valid", o_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_o_valid", o_valid, 0);
        chk("abort_o_d", o_d, 0);
        chk("abort_ld_ready", ld_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        q.delete();
        active = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        active   = 1'b0;
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_len   = '0;
        ld_rep   = '0;
        #1;
        reset = 1'b1;
        #1;
        chk("reset_ld_ready", ld_ready, 1);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_d", o_d, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_load(16'hA5C3, 16, 0, 1'b0);
        do_load(16'h0005, 3, 2, 1'b0);
        do_load(16'h1234, 0, 0, 1'b0);
        do_load(16'hBEEF, 20, 0, 1'b0);
        do_load(16'hA5C3, 16, 0, 1'b1);
        do_load(16'h0001, 1, 0, 1'b0);
        do_load(16'hFFFE, 16, 15, 1'b0);

        reset_mid_transfer();
        do_load(16'h5A5A, 7, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_load(W'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter W, default 16, pattern register width in bits (legal range 2..64).
REQ-002 Parameter LW, default $clog2(W+1), width of the length field.
REQ-003 Port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port ld_valid  input  1  load request.
REQ-006 Port ld_data  input  W  pattern to transmit, LSB first.
REQ-007 Port ld_len  input  LW  number of pattern bits to send, 1..W; values 0 and >W are treated as W.
REQ-008 Port ld_rep  input  4  extra repetitions; the pattern is sent ld_rep+1 times.
REQ-009 Port ld_ready  output  1  block can accept a load.
REQ-010 Port o_d  output  1  serial data bit, one per clock, feeds a sequence-detector i_d.
REQ-011 Port o_valid  output  1  o_d carries a pattern bit this cycle.
REQ-012 Port busy  output  1  block is in SHIFT or DONE.
REQ-013 Port done  output  1  one-cycle pulse after the final bit.

Function
REQ-014 The block SHALL implement the three states IDLE, SHIFT and DONE.
REQ-015 In IDLE, ld_ready SHALL be 1; in SHIFT and DONE, it SHALL be 0.
REQ-016 A load SHALL be accepted on the edge where ld_valid=1 and ld_ready=1; data, effective length and repetition count are captured and the state goes to SHIFT.
REQ-017 Latency: the first bit (ld_data[0]) SHALL appear on o_d with o_valid=1 in the cycle immediately after acceptance.
REQ-018 In SHIFT, o_d SHALL present bit k of the captured pattern for k = 0..len-1, one bit per cycle, with o_valid=1 continuously.
REQ-019 After bit len-1, if repetitions remain, the next cycle SHALL present bit 0 again with no gap and the repetition count SHALL decrement; otherwise the state SHALL go to DONE.
REQ-020 Total o_valid cycles per load SHALL equal len*(ld_rep+1), from 1 up to 16*W.
REQ-021 DONE SHALL last exactly one cycle with done=1, o_valid=0 and o_d=0, then the state goes to IDLE.
REQ-022 Whenever o_valid=0, o_d SHALL be 0.
REQ-023 ld_valid asserted while ld_ready=0 SHALL be ignored; it is not queued and does not disturb the transfer in progress.
REQ-024 ld_data, ld_len and ld_rep changing after acceptance SHALL have no effect on the transfer.
REQ-025 A new load SHALL be accepted no earlier than the IDLE cycle after DONE, giving a minimum of one idle cycle with o_valid=0 between transfers.
REQ-026 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 Assertion of reset SHALL immediately, without waiting for clk, force: state IDLE, ld_ready=1, o_d=0, o_valid=0, busy=0, done=0; the pattern, bit index and repetition count are cleared to 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer, with no done pulse issued.
REQ-029 On the first edge after reset is released, a load SHALL be acceptable.

Structure
REQ-030 The state enumeration (IDLE/SHIFT/DONE) and the default W SHALL reside in a shared package, seq_pattern_pkg.
REQ-031 The bit-index and repetition counters SHALL be one sub-module, seq_bit_counter, providing load, decrement and wrap signalling.

Verification
REQ-032 W=16, ld_data=16'hA5C3, ld_len=16, ld_rep=0 -> o_d = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles; done pulses in cycle 17 after acceptance; ld_ready returns to 1 in cycle 18.
REQ-033 ld_data=16'h0005, ld_len=3, ld_rep=2 -> o_d = 101101101 over 9 contiguous o_valid cycles, then done.
REQ-034 ld_len=0 and ld_len=20 with W=16 -> each sends 16 bits.
REQ-035 Second ld_valid pulse during SHIFT with different data -> ignored; the output stream is unchanged and exactly one done pulse occurs.
REQ-036 Reset asserted asynchronously, between clk edges, at bit 5 of a 16-bit transfer -> o_valid=0, o_d=0 and ld_ready=1 before the next edge; no done pulse.
REQ-037 Loopback: o_d drives the i_d input of the team's Moore sequence detector with the detector's 60-bit test pattern, sent as four 15-bit loads -> detector o_d matches the response obtained from direct stimulus, offset by the inter-load idle cycles.
